// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, opcodes
// and the select/control codes consumed by Sign_extention and the datapath.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWRITE = 4'd4,
      MEMWB    = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      JAL      = 4'd10,
      ERROR    = 4'd11
   } state_t;

   localparam logic [6:0] OP_LW     = 7'b0000011;
   localparam logic [6:0] OP_SW     = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // ALUOp: what the FSM asks of alu_decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   function automatic logic is_mem_state(input state_t s);
      return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from ALUOp and instruction fields; flags
// funct3 values the core does not implement.
module alu_decoder (
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [2:0] alu_control,
   output logic       funct_illegal
);
   import riscv_ctrl_pkg::*;

   always_comb begin
      alu_control   = ALU_ADD;
      funct_illegal = 1'b0;
      case (alu_op)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // op5 separates R-type from I-type; addi never subtracts
               3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: funct_illegal = 1'b1;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RV32I core: sequences shared ALU, register
// file and unified memory, with illegal-opcode and memory-timeout detection.
module multicycle_controller #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       MemReq,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [1:0] ImmSrc,
   output logic       IllegalInstr,
   output logic       Error,
   output logic [3:0] dbg_state
);
   import riscv_ctrl_pkg::*;

   localparam int CW = $clog2(MEM_TIMEOUT + 1);

   state_t         state, state_next;
   logic [CW-1:0]  tmo_cnt;
   logic           error_q;

   logic [1:0] alu_op;
   logic [2:0] alu_control_dec;
   logic       funct_illegal;

   logic       pc_update, branch, branch_taken, mem_wait, tmo_hit;
   logic       adr_c, mw_c, mr_c, irw_c, rw_c, ill_c;
   logic [1:0] rs_c, sa_c, sb_c, imm_c;

   alu_decoder u_alu_decoder (
      .alu_op        (alu_op),
      .funct3        (funct3),
      .funct7b5      (funct7b5),
      .op5           (op[5]),
      .alu_control   (alu_control_dec),
      .funct_illegal (funct_illegal)
   );

   // Memory handshake: MemReq is held high for the whole memory state and the
   // access completes on the cycle MemReady is sampled high; MemReady is a
   // don't-care in every other state.
   assign mem_wait = is_mem_state(state) && !MemReady;
   assign tmo_hit  = mem_wait && (tmo_cnt == CW'(MEM_TIMEOUT - 1));

   always_comb begin
      branch_taken = 1'b0;
      if (funct3 == 3'b000)      branch_taken = Zero;
      else if (funct3 == 3'b001) branch_taken = !Zero;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FETCH;
      else        state <= state_next;
   end

   // Clearing on any state change covers entry into every memory state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   tmo_cnt <= '0;
      else if (state_next != state) tmo_cnt <= '0;
      else if (mem_wait)            tmo_cnt <= tmo_cnt + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   error_q <= 1'b0;
      else if (state_next == ERROR) error_q <= 1'b1;
   end

   always_comb begin
      state_next = state;
      pc_update  = 1'b0;
      branch     = 1'b0;
      adr_c      = 1'b0;
      mw_c       = 1'b0;
      mr_c       = 1'b0;
      irw_c      = 1'b0;
      rw_c       = 1'b0;
      ill_c      = 1'b0;
      rs_c       = RES_ALUOUT;
      sa_c       = SRCA_PC;
      sb_c       = SRCB_RD2;
      imm_c      = IMM_I;
      alu_op     = ALUOP_ADD;
      case (state)
         FETCH: begin
            mr_c = 1'b1;
            sa_c = SRCA_PC;
            sb_c = SRCB_FOUR;
            rs_c = RES_ALURESULT;
            if (MemReady) begin
               irw_c      = 1'b1;
               pc_update  = 1'b1;
               state_next = DECODE;
            end else if (tmo_hit) begin
               state_next = ERROR;
            end
         end
         DECODE: begin
            // Branch target is precomputed here into ALUOut
            sa_c  = SRCA_OLDPC;
            sb_c  = SRCB_IMM;
            imm_c = IMM_B;
            case (op)
               OP_LW, OP_SW: state_next = MEMADR;
               OP_RTYPE:     state_next = EXECR;
               OP_ITYPE:     state_next = EXECI;
               OP_JAL:       state_next = JAL;
               OP_BRANCH:    state_next = BRANCH;
               default: begin
                  ill_c      = 1'b1;
                  state_next = FETCH;
               end
            endcase
         end
         MEMADR: begin
            sa_c       = SRCA_RD1;
            sb_c       = SRCB_IMM;
            imm_c      = op[5] ? IMM_S : IMM_I;
            state_next = op[5] ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            mr_c  = 1'b1;
            adr_c = 1'b1;
            if (MemReady)     state_next = MEMWB;
            else if (tmo_hit) state_next = ERROR;
         end
         MEMWRITE: begin
            mr_c  = 1'b1;
            mw_c  = 1'b1;
            adr_c = 1'b1;
            if (MemReady)     state_next = FETCH;
            else if (tmo_hit) state_next = ERROR;
         end
         MEMWB: begin
            rs_c       = RES_DATA;
            rw_c       = 1'b1;
            state_next = FETCH;
         end
         EXECR, EXECI: begin
            sa_c   = SRCA_RD1;
            sb_c   = (state == EXECI) ? SRCB_IMM : SRCB_RD2;
            imm_c  = IMM_I;
            alu_op = ALUOP_FUNCT;
            if (funct_illegal) begin
               ill_c      = 1'b1;
               state_next = FETCH;
            end else begin
               state_next = ALUWB;
            end
         end
         ALUWB: begin
            rs_c       = RES_ALUOUT;
            rw_c       = 1'b1;
            state_next = FETCH;
         end
         BRANCH: begin
            sa_c       = SRCA_RD1;
            sb_c       = SRCB_RD2;
            alu_op     = ALUOP_SUB;
            rs_c       = RES_ALUOUT;
            branch     = 1'b1;
            state_next = FETCH;
         end
         JAL: begin
            // PC takes the DECODE target from ALUOut while ALU forms OldPC+4 for rd
            sa_c       = SRCA_OLDPC;
            sb_c       = SRCB_FOUR;
            rs_c       = RES_ALUOUT;
            pc_update  = 1'b1;
            state_next = ALUWB;
         end
         ERROR:   state_next = ERROR;
         default: state_next = FETCH;
      endcase
   end

   // Reset gates outputs combinationally so no enable glitches while rst_n is low
   assign PCWrite      = rst_n && (pc_update || (branch && branch_taken));
   assign AdrSrc       = rst_n && adr_c;
   assign MemWrite     = rst_n && mw_c;
   assign MemReq       = rst_n && mr_c;
   assign IRWrite      = rst_n && irw_c;
   assign RegWrite     = rst_n && rw_c;
   assign IllegalInstr = rst_n && ill_c;
   assign ResultSrc    = rst_n ? rs_c : 2'b00;
   assign ALUSrcA      = rst_n ? sa_c : 2'b00;
   assign ALUSrcB      = rst_n ? sb_c : 2'b00;
   assign ImmSrc       = rst_n ? imm_c : 2'b00;
   assign ALUControl   = rst_n ? alu_control_dec : 3'b000;
   assign Error        = error_q;
   assign dbg_state    = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected control vectors
// are queued by the driver and compared by a negedge monitor.
module tb_multicycle_controller;

   logic       clk;
   logic       rst_n;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic       MemReady;
   logic       PCWrite, AdrSrc, MemWrite, MemReq, IRWrite, RegWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic       IllegalInstr, Error;
   logic [3:0] dbg_state;

   multicycle_controller #(.MEM_TIMEOUT(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .op           (op),
      .funct3       (funct3),
      .funct7b5     (funct7b5),
      .Zero         (Zero),
      .MemReady     (MemReady),
      .PCWrite      (PCWrite),
      .AdrSrc       (AdrSrc),
      .MemWrite     (MemWrite),
      .MemReq       (MemReq),
      .IRWrite      (IRWrite),
      .RegWrite     (RegWrite),
      .ResultSrc    (ResultSrc),
      .ALUSrcA      (ALUSrcA),
      .ALUSrcB      (ALUSrcB),
      .ALUControl   (ALUControl),
      .ImmSrc       (ImmSrc),
      .IllegalInstr (IllegalInstr),
      .Error        (Error),
      .dbg_state    (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] JL  = 7'b1101111;
   localparam logic [6:0] BR  = 7'b1100011;
   localparam logic [6:0] BAD = 7'b0000000;

   // vector = {state, PCWrite, AdrSrc, MemWrite, MemReq, IRWrite, RegWrite,
   //           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, IllegalInstr, Error}
   function automatic logic [22:0] v(input logic [3:0] st, input logic [5:0] en,
                                     input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [2:0] alu,
                                     input logic [1:0] imm, input logic ill,
                                     input logic err);
      return {st, en, rs, sa, sb, alu, imm, ill, err};
   endfunction

   logic [22:0] exp_q[$];
   string       name_q[$];
   int          tests = 0;
   int          fails = 0;

   logic [22:0] v_rst, v_fetch_rdy, v_fetch_wait, v_decode, v_decode_ill;
   logic [22:0] v_memadr_lw, v_memadr_sw, v_memread, v_memwrite, v_memwb;
   logic [22:0] v_aluwb, v_error;

   // driver
   task automatic step(input logic r, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z, input logic rdy,
                       input logic [22:0] e, input string nm);
      @(posedge clk);
      #1;
      rst_n    = r;
      op       = o;
      funct3   = f3;
      funct7b5 = f7;
      Zero     = z;
      MemReady = rdy;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // scoreboard monitor
   logic [22:0] mon_exp, mon_got;
   string       mon_name;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_exp  = exp_q.pop_front();
         mon_name = name_q.pop_front();
         mon_got  = {dbg_state, PCWrite, AdrSrc, MemWrite, MemReq, IRWrite, RegWrite,
                     ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, IllegalInstr, Error};
         tests++;
         if (mon_got !== mon_exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", mon_name, mon_got, mon_exp);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      v_rst        = '0;
      v_fetch_rdy  = v(4'd0,  6'b100110, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 1'b0, 1'b0);
      v_fetch_wait = v(4'd0,  6'b000100, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 1'b0, 1'b0);
      v_decode     = v(4'd1,  6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b10, 1'b0, 1'b0);
      v_decode_ill = v(4'd1,  6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b10, 1'b1, 1'b0);
      v_memadr_lw  = v(4'd2,  6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0);
      v_memadr_sw  = v(4'd2,  6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 1'b0, 1'b0);
      v_memread    = v(4'd3,  6'b010100, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0);
      v_memwrite   = v(4'd4,  6'b011100, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0);
      v_memwb      = v(4'd5,  6'b000001, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0);
      v_aluwb      = v(4'd8,  6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0);
      v_error      = v(4'd11, 6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1);

      rst_n = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b1;

      step(0, LW, 3'b010, 0, 0, 1, v_rst, "reset_0");
      step(0, LW, 3'b010, 0, 0, 1, v_rst, "reset_1");

      // lw x9,-4(x9)
      step(1, LW, 3'b010, 0, 0, 1, v_fetch_rdy, "lw_fetch");
      step(1, LW, 3'b010, 0, 0, 1, v_decode,    "lw_decode");
      step(1, LW, 3'b010, 0, 0, 1, v_memadr_lw, "lw_memadr");
      step(1, LW, 3'b010, 0, 0, 1, v_memread,   "lw_memread");
      step(1, LW, 3'b010, 0, 0, 1, v_memwb,     "lw_memwb");

      // sw
      step(1, SW, 3'b010, 0, 0, 1, v_fetch_rdy, "sw_fetch");
      step(1, SW, 3'b010, 0, 0, 1, v_decode,    "sw_decode");
      step(1, SW, 3'b010, 0, 0, 1, v_memadr_sw, "sw_memadr");
      step(1, SW, 3'b010, 0, 0, 1, v_memwrite,  "sw_memwrite");

      // beq taken, bne not taken, both with Zero=1
      step(1, BR, 3'b000, 0, 1, 1, v_fetch_rdy, "beq_fetch");
      step(1, BR, 3'b000, 0, 1, 1, v_decode,    "beq_decode");
      step(1, BR, 3'b000, 0, 1, 1,
           v(4'd9, 6'b100000, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 1'b0, 1'b0), "beq_branch");
      step(1, BR, 3'b001, 0, 1, 1, v_fetch_rdy, "bne_fetch");
      step(1, BR, 3'b001, 0, 1, 1, v_decode,    "bne_decode");
      step(1, BR, 3'b001, 0, 1, 1,
           v(4'd9, 6'b000000, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 1'b0, 1'b0), "bne_branch");

      // R-type sub
      step(1, RT, 3'b000, 1, 0, 1, v_fetch_rdy, "sub_fetch");
      step(1, RT, 3'b000, 1, 0, 1, v_decode,    "sub_decode");
      step(1, RT, 3'b000, 1, 0, 1,
           v(4'd6, 6'b000000, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 1'b0, 1'b0), "sub_execr");
      step(1, RT, 3'b000, 1, 0, 1, v_aluwb,     "sub_aluwb");

      // addi with Instr[30]=1 must still add
      step(1, IT, 3'b000, 1, 0, 1, v_fetch_rdy, "addi_fetch");
      step(1, IT, 3'b000, 1, 0, 1, v_decode,    "addi_decode");
      step(1, IT, 3'b000, 1, 0, 1,
           v(4'd7, 6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0), "addi_execi");
      step(1, IT, 3'b000, 1, 0, 1, v_aluwb,     "addi_aluwb");

      // ori
      step(1, IT, 3'b110, 0, 0, 1, v_fetch_rdy, "ori_fetch");
      step(1, IT, 3'b110, 0, 0, 1, v_decode,    "ori_decode");
      step(1, IT, 3'b110, 0, 0, 1,
           v(4'd7, 6'b000000, 2'b00, 2'b10, 2'b01, 3'b011, 2'b00, 1'b0, 1'b0), "ori_execi");
      step(1, IT, 3'b110, 0, 0, 1, v_aluwb,     "ori_aluwb");

      // slt and and
      step(1, RT, 3'b010, 0, 0, 1, v_fetch_rdy, "slt_fetch");
      step(1, RT, 3'b010, 0, 0, 1, v_decode,    "slt_decode");
      step(1, RT, 3'b010, 0, 0, 1,
           v(4'd6, 6'b000000, 2'b00, 2'b10, 2'b00, 3'b101, 2'b00, 1'b0, 1'b0), "slt_execr");
      step(1, RT, 3'b010, 0, 0, 1, v_aluwb,     "slt_aluwb");
      step(1, RT, 3'b111, 0, 0, 1, v_fetch_rdy, "and_fetch");
      step(1, RT, 3'b111, 0, 0, 1, v_decode,    "and_decode");
      step(1, RT, 3'b111, 0, 0, 1,
           v(4'd6, 6'b000000, 2'b00, 2'b10, 2'b00, 3'b010, 2'b00, 1'b0, 1'b0), "and_execr");
      step(1, RT, 3'b111, 0, 0, 1, v_aluwb,     "and_aluwb");

      // sll is unsupported: illegal pulse in EXECR, no writeback
      step(1, RT, 3'b001, 0, 0, 1, v_fetch_rdy, "sll_fetch");
      step(1, RT, 3'b001, 0, 0, 1, v_decode,    "sll_decode");
      step(1, RT, 3'b001, 0, 0, 1,
           v(4'd6, 6'b000000, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0), "sll_execr");

      // jal
      step(1, JL, 3'b000, 0, 0, 1, v_fetch_rdy, "jal_fetch");
      step(1, JL, 3'b000, 0, 0, 1, v_decode,    "jal_decode");
      step(1, JL, 3'b000, 0, 0, 1,
           v(4'd10, 6'b100000, 2'b00, 2'b01, 2'b10, 3'b000, 2'b00, 1'b0, 1'b0), "jal_jal");
      step(1, JL, 3'b000, 0, 0, 1, v_aluwb,     "jal_aluwb");

      // illegal opcode
      step(1, BAD, 3'b000, 0, 0, 1, v_fetch_rdy,  "ill_fetch");
      step(1, BAD, 3'b000, 0, 0, 1, v_decode_ill, "ill_decode");

      // fetch stalled 3 cycles, completes on the 4th
      for (int i = 0; i < 3; i++)
         step(1, BAD, 3'b000, 0, 0, 0, v_fetch_wait, "stall_fetch_wait");
      step(1, BAD, 3'b000, 0, 0, 1, v_fetch_rdy,  "stall_fetch_done");
      step(1, BAD, 3'b000, 0, 0, 1, v_decode_ill, "stall_decode");

      // MemReady on the limit cycle wins over the timeout
      step(1, LW, 3'b010, 0, 0, 1, v_fetch_rdy, "edge_fetch");
      step(1, LW, 3'b010, 0, 0, 1, v_decode,    "edge_decode");
      step(1, LW, 3'b010, 0, 0, 1, v_memadr_lw, "edge_memadr");
      for (int i = 0; i < 15; i++)
         step(1, LW, 3'b010, 0, 0, 0, v_memread, "edge_memread_wait");
      step(1, LW, 3'b010, 0, 0, 1, v_memread,   "edge_memread_done");
      step(1, LW, 3'b010, 0, 0, 1, v_memwb,     "edge_memwb");

      // fetch timeout after 16 idle cycles, ERROR ignores MemReady
      for (int i = 0; i < 16; i++)
         step(1, BAD, 3'b000, 0, 0, 0, v_fetch_wait, "tmo_fetch_wait");
      step(1, BAD, 3'b000, 0, 0, 1, v_error, "tmo_error_0");
      step(1, BAD, 3'b000, 0, 0, 1, v_error, "tmo_error_1");
      step(0, BAD, 3'b000, 0, 0, 1, v_rst,   "tmo_reset");
      step(1, BAD, 3'b000, 0, 0, 1, v_fetch_rdy,  "tmo_refetch");
      step(1, BAD, 3'b000, 0, 0, 1, v_decode_ill, "tmo_redecode");

      // reset during a stalled store
      step(1, SW, 3'b010, 0, 0, 1, v_fetch_rdy, "mr_fetch");
      step(1, SW, 3'b010, 0, 0, 1, v_decode,    "mr_decode");
      step(1, SW, 3'b010, 0, 0, 1, v_memadr_sw, "mr_memadr");
      step(1, SW, 3'b010, 0, 0, 0, v_memwrite,  "mr_memwrite_0");
      step(1, SW, 3'b010, 0, 0, 0, v_memwrite,  "mr_memwrite_1");
      step(0, SW, 3'b010, 0, 0, 0, v_rst,       "mr_reset");
      step(1, SW, 3'b010, 0, 0, 0, v_fetch_wait, "mr_fetch_wait");
      step(1, SW, 3'b010, 0, 0, 1, v_fetch_rdy,  "mr_fetch_done");

      @(negedge clk);
      #1;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
